// File: rtl/tb_cpld_pkg.sv
// Shared region/state encodings and the 68K address map for the test-board CPLD.
package tb_cpld_pkg;

  typedef enum logic [2:0] {
    RGN_NONE = 3'd0,
    RGN_WRAM = 3'd1,
    RGN_CARD = 3'd2,
    RGN_SROM = 3'd3,
    RGN_SRAM = 3'd4
  } region_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_TMO    = 3'd4;

  // Compared against byte-address bits [23:20] (card uses [23:22]).
  localparam logic [3:0] MAP_WRAM_HI = 4'h1;
  localparam logic [1:0] MAP_CARD_HI = 2'b10;
  localparam logic [3:0] MAP_SROM_HI = 4'hC;
  localparam logic [3:0] MAP_SRAM_HI = 4'hD;

endpackage

// File: rtl/tb_cpld_decode.sv
// Combinational 68K address-to-region decoder; zero latency, no flow control.
module tb_cpld_decode
  import tb_cpld_pkg::*;
(
  input  logic [23:1] addr_i,
  output logic [2:0]  region_o
);

  // Only the top nibble selects a region; the rest is deliberately ignored.
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_i[19:1];

  always_comb begin
    region_o = RGN_NONE;
    if (addr_i[23:20] == MAP_WRAM_HI)      region_o = RGN_WRAM;
    else if (addr_i[23:22] == MAP_CARD_HI) region_o = RGN_CARD;
    else if (addr_i[23:20] == MAP_SROM_HI) region_o = RGN_SROM;
    else if (addr_i[23:20] == MAP_SRAM_HI) region_o = RGN_SRAM;
  end

endmodule

// File: rtl/tb_cpld_memctl.sv
// 68K memory controller: selects valid 2 edges after nAS falls, nDTACK WS+1 cycles after DECODE.
// nBERR after BERR_TIMEOUT+1 unacknowledged cycles; nAS rising aborts and releases every strobe.
module tb_cpld_memctl
  import tb_cpld_pkg::*;
#(
  parameter int         WS_SROM      = 2,
  parameter int         WS_WRAM      = 0,
  parameter int         WS_SRAM      = 2,
  parameter int         WS_CARD      = 4,
  parameter logic [7:0] BERR_TIMEOUT = 8'd255
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic [23:1] M68K_ADDR,
  input  logic        M68K_RW,
  input  logic        nAS,
  input  logic        nLDS,
  input  logic        nUDS,
  input  logic        nEXT_DTACK,
  input  logic        nSRAMWEN,
  input  logic        nCD1,
  input  logic        nCD2,
  output logic        nSROMOE,
  output logic        nWRAMOEL,
  output logic        nWRAMOEU,
  output logic        nWRAMWEL,
  output logic        nWRAMWEU,
  output logic        nSRAMOEL,
  output logic        nSRAMOEU,
  output logic        nSRAMWEL,
  output logic        nSRAMWEU,
  output logic        nCRDC,
  output logic        nCRDO,
  output logic        nCRDW,
  output logic        nDTACK,
  output logic        nBERR
);

  logic [23:1] addr_q;
  logic        rw_in_q, as_q, lds_q, uds_q;

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      addr_q  <= '0;
      rw_in_q <= 1'b1;
      as_q    <= 1'b1;
      lds_q   <= 1'b1;
      uds_q   <= 1'b1;
    end else begin
      addr_q  <= M68K_ADDR;
      rw_in_q <= M68K_RW;
      as_q    <= nAS;
      lds_q   <= nLDS;
      uds_q   <= nUDS;
    end
  end

  logic [2:0] region_dec;

  tb_cpld_decode u_decode (
    .addr_i   (addr_q),
    .region_o (region_dec)
  );

  logic [2:0] state_q, state_d, region_q, region_d;
  logic       rw_q, rw_d, own_ack_q, own_ack_d, berr_q, berr_d;
  logic [7:0] wait_q, wait_d, tmo_q, tmo_d;

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    rw_d      = rw_q;
    own_ack_d = own_ack_q;
    berr_d    = berr_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_IDLE: begin
        own_ack_d = 1'b0;
        berr_d    = 1'b0;
        if (!as_q) begin
          region_d = region_dec;
          rw_d     = rw_in_q;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        tmo_d = '0;
        case (region_q)
          RGN_WRAM: wait_d = 8'(WS_WRAM);
          RGN_CARD: wait_d = 8'(WS_CARD);
          RGN_SROM: wait_d = 8'(WS_SROM);
          RGN_SRAM: wait_d = 8'(WS_SRAM);
          default:  wait_d = '0;
        endcase
        state_d = (region_q == RGN_NONE) ? ST_TMO : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          own_ack_d = 1'b1;
          state_d   = ST_ACK;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      ST_ACK: ;
      ST_TMO: begin
        if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
        // Another agent answered: finish the cycle silently.
        if (!nEXT_DTACK) begin
          state_d = ST_ACK;
        end else if (tmo_q == BERR_TIMEOUT) begin
          berr_d  = 1'b1;
          state_d = ST_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && as_q) begin
      state_d   = ST_IDLE;
      own_ack_d = 1'b0;
      berr_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= ST_IDLE;
      region_q  <= RGN_NONE;
      rw_q      <= 1'b1;
      own_ack_q <= 1'b0;
      berr_q    <= 1'b0;
      wait_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      rw_q      <= rw_d;
      own_ack_q <= own_ack_d;
      berr_q    <= berr_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
    end
  end

  // Strobes are gated by the registered nAS so an abort releases them before the FSM leaves.
  logic sel, rd, wr, lo, hi, any_ds, card_in, s_wram, s_sram, s_srom, s_card;

  assign sel     = !as_q && (state_q == ST_DECODE || state_q == ST_WAIT || state_q == ST_ACK);
  assign rd      = rw_q;
  assign wr      = !rw_q;
  assign lo      = !lds_q;
  assign hi      = !uds_q;
  assign any_ds  = lo | hi;
  assign card_in = !(nCD1 | nCD2);
  assign s_wram  = sel && (region_q == RGN_WRAM);
  assign s_sram  = sel && (region_q == RGN_SRAM);
  assign s_srom  = sel && (region_q == RGN_SROM);
  assign s_card  = sel && (region_q == RGN_CARD);

  assign nSROMOE  = !(s_srom && rd && any_ds);
  assign nWRAMOEL = !(s_wram && rd && lo);
  assign nWRAMOEU = !(s_wram && rd && hi);
  assign nWRAMWEL = !(s_wram && wr && lo);
  assign nWRAMWEU = !(s_wram && wr && hi);
  assign nSRAMOEL = !(s_sram && rd && lo);
  assign nSRAMOEU = !(s_sram && rd && hi);
  assign nSRAMWEL = !(s_sram && wr && lo && !nSRAMWEN);
  assign nSRAMWEU = !(s_sram && wr && hi && !nSRAMWEN);
  assign nCRDC    = !s_card;
  assign nCRDO    = !(s_card && rd && any_ds && card_in);
  assign nCRDW    = !(s_card && wr && any_ds && card_in);

  assign nDTACK = !(!as_q && ((state_q == ST_WAIT && wait_q == '0) ||
                              (state_q == ST_ACK && own_ack_q)));
  assign nBERR  = !(!as_q && state_q == ST_ACK && berr_q);

endmodule

// File: tb/tb_tb_cpld_memctl.sv
// Directed bench for tb_cpld_memctl: edge-accurate strobe, nDTACK and nBERR checks per region.
module tb_tb_cpld_memctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:1] addr;
  logic        rwn, nas, nlds, nuds, next_dtack, sramwen_n, cd1_n, cd2_n;
  logic        srom_oe, woel, woeu, wwel, wweu, soel, soeu, swel, sweu;
  logic        crdc, crdo, crdw, dtack, berr;
  logic [13:0] outs;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [13:0] ALL_HI = 14'h3FFF;
  localparam logic [13:0] B_SROMOE = 14'h2000;
  localparam logic [13:0] B_WOEL   = 14'h1000;
  localparam logic [13:0] B_WOEU   = 14'h0800;
  localparam logic [13:0] B_WWEL   = 14'h0400;
  localparam logic [13:0] B_WWEU   = 14'h0200;
  localparam logic [13:0] B_SWEL   = 14'h0040;
  localparam logic [13:0] B_CRDC   = 14'h0010;
  localparam logic [13:0] B_CRDO   = 14'h0008;
  localparam logic [13:0] B_DTACK  = 14'h0002;
  localparam logic [13:0] B_BERR   = 14'h0001;

  always #5 clk = ~clk;

  tb_cpld_memctl dut (
    .CLK_24M    (clk),
    .nRESET     (rst_n),
    .M68K_ADDR  (addr),
    .M68K_RW    (rwn),
    .nAS        (nas),
    .nLDS       (nlds),
    .nUDS       (nuds),
    .nEXT_DTACK (next_dtack),
    .nSRAMWEN   (sramwen_n),
    .nCD1       (cd1_n),
    .nCD2       (cd2_n),
    .nSROMOE    (srom_oe),
    .nWRAMOEL   (woel),
    .nWRAMOEU   (woeu),
    .nWRAMWEL   (wwel),
    .nWRAMWEU   (wweu),
    .nSRAMOEL   (soel),
    .nSRAMOEU   (soeu),
    .nSRAMWEL   (swel),
    .nSRAMWEU   (sweu),
    .nCRDC      (crdc),
    .nCRDO      (crdo),
    .nCRDW      (crdw),
    .nDTACK     (dtack),
    .nBERR      (berr)
  );

  assign outs = {srom_oe, woel, woeu, wwel, wweu, soel, soeu, swel, sweu,
                 crdc, crdo, crdw, dtack, berr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Returns 2 time units after the n-th following rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_start(input logic [23:0] a, input logic rw, input logic lds, input logic uds);
    logic [23:0] a_v;
    a_v  = a;
    addr = a_v[23:1];
    rwn  = rw;
    nlds = lds;
    nuds = uds;
    nas  = 1'b0;
  endtask

  task automatic bus_end();
    nas  = 1'b1;
    nlds = 1'b1;
    nuds = 1'b1;
    rwn  = 1'b1;
  endtask

  initial begin
    int edge_n, bad;
    rst_n = 1'b0; addr = '0; rwn = 1'b1; nas = 1'b1; nlds = 1'b1; nuds = 1'b1;
    next_dtack = 1'b1; sramwen_n = 1'b1; cd1_n = 1'b1; cd2_n = 1'b1;
    #1;
    chk("reset_outs", outs, ALL_HI);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // WRAM word write, WS=0
    bus_start(24'h100000, 1'b0, 1'b0, 1'b0);
    tick(1); chk("wram_e1", outs, ALL_HI);
    tick(1); chk("wram_e2", outs, ALL_HI & ~(B_WWEL | B_WWEU));
    tick(1); chk("wram_e3", outs, ALL_HI & ~(B_WWEL | B_WWEU | B_DTACK));
    bus_end();
    tick(1); chk("wram_release", outs, ALL_HI);
    tick(2);

    // SROM read then write, WS=2
    bus_start(24'hC11D46, 1'b1, 1'b0, 1'b0);
    tick(4); chk("srom_rd_e4", outs, ALL_HI & ~B_SROMOE);
    tick(1); chk("srom_rd_e5", outs, ALL_HI & ~(B_SROMOE | B_DTACK));
    bus_end(); tick(3);
    bus_start(24'hC11D46, 1'b0, 1'b0, 1'b0);
    tick(4); chk("srom_wr_e4", outs, ALL_HI);
    tick(1); chk("srom_wr_e5", outs, ALL_HI & ~B_DTACK);
    bus_end(); tick(3);

    // SRAM byte write, locked then unlocked
    bus_start(24'hD00001, 1'b0, 1'b0, 1'b1);
    tick(2); chk("sram_lock_e2", outs, ALL_HI);
    tick(3); chk("sram_lock_e5", outs, ALL_HI & ~B_DTACK);
    bus_end(); tick(3);
    sramwen_n = 1'b0;
    bus_start(24'hD00001, 1'b0, 1'b0, 1'b1);
    tick(2); chk("sram_wr_e2", outs, ALL_HI & ~B_SWEL);
    tick(3); chk("sram_wr_e5", outs, ALL_HI & ~(B_SWEL | B_DTACK));
    bus_end(); tick(3);
    sramwen_n = 1'b1;

    // Card read, absent then present, WS=4
    bus_start(24'h800000, 1'b1, 1'b0, 1'b0);
    tick(6); chk("card_abs_e6", outs, ALL_HI & ~B_CRDC);
    tick(1); chk("card_abs_e7", outs, ALL_HI & ~(B_CRDC | B_DTACK));
    bus_end(); tick(3);
    cd1_n = 1'b0; cd2_n = 1'b0;
    bus_start(24'h800000, 1'b1, 1'b0, 1'b0);
    tick(2); chk("card_in_e2", outs, ALL_HI & ~(B_CRDC | B_CRDO));
    tick(5); chk("card_in_e7", outs, ALL_HI & ~(B_CRDC | B_CRDO | B_DTACK));
    bus_end(); tick(3);

    // Unmapped read: timeout to nBERR (DECODE e2, TMO e3, nBERR e3+256)
    bus_start(24'h400000, 1'b1, 1'b0, 1'b0);
    edge_n = 0;
    for (int e = 1; e <= 400; e++) begin
      tick(1);
      if (berr === 1'b0) begin
        edge_n = e;
        break;
      end
    end
    chk("berr_edge", edge_n, 259);
    chk("berr_outs", outs, ALL_HI & ~B_BERR);
    bus_end(); tick(3);

    // Unmapped read answered externally after edge 10
    bus_start(24'h400000, 1'b1, 1'b0, 1'b0);
    bad = 0;
    for (int e = 1; e <= 300; e++) begin
      tick(1);
      if (e == 10) next_dtack = 1'b0;
      if (dtack !== 1'b1 || berr !== 1'b1) bad++;
    end
    chk("ext_quiet", bad, 0);
    bus_end(); next_dtack = 1'b1; tick(3);

    // Abort during card WAIT
    bus_start(24'h800000, 1'b1, 1'b0, 1'b0);
    tick(4); chk("abort_e4", outs, ALL_HI & ~(B_CRDC | B_CRDO));
    bus_end();
    tick(2); chk("abort_e6", outs, ALL_HI);
    bad = 0;
    for (int e = 7; e <= 12; e++) begin
      tick(1);
      if (outs !== ALL_HI) bad++;
    end
    chk("abort_quiet", bad, 0);

    // Recovery: WRAM upper-byte read at top of region
    bus_start(24'h1FFFFE, 1'b1, 1'b1, 1'b0);
    tick(2); chk("wram_rd_e2", outs, ALL_HI & ~B_WOEU);
    tick(1); chk("wram_rd_e3", outs, ALL_HI & ~(B_WOEU | B_DTACK));
    bus_end(); tick(3);

    // Reset while in ACK
    bus_start(24'h100000, 1'b0, 1'b0, 1'b0);
    tick(4); chk("rst_pre", outs, ALL_HI & ~(B_WWEL | B_WWEU | B_DTACK));
    #1 rst_n = 1'b0;
    #1 chk("rst_async", outs, ALL_HI);
    bus_end();
    tick(1);
    rst_n = 1'b1;
    tick(2); chk("rst_after", outs, ALL_HI);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
